encoder_loader: RTL and testbench
=================================

# encoder_loader

Upstream feeder for the encoder core. Accepts a stream of `WORD_W`-bit words over a valid/ready handshake and assembles them into one `N_CELLS`-bit block. When the block is complete it pulses the encoder's start input. It holds the block stable on the encoder's data input until the encoder reports done, then reopens for the next block.

## Interface

Parameters:
- `N_CELLS`, default `` `NUM_CELLS ``: block width in bits; must be an exact multiple of `WORD_W`.
- `WORD_W`, default 64: input word width.
- Derived (localparam, not overridable):
  - `WORDS` = `N_CELLS / WORD_W`.
  - `CNT_W` = `$clog2(WORDS)`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_data`, input, `WORD_W`: input word.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_last`, input, 1: marks the final word of a short block; used only when `LOADER_PAD_EN` is defined.
- `in_ready`, output, 1: loader accepts a word this cycle.
- `enc_start`, output, 1: one-cycle start pulse to the encoder.
- `enc_done`, input, 1: encoder's done output.
- `enc_data_in`, output, `N_CELLS`: assembled block, driving the encoder's data input.
- `blk_done`, output, 1: one-cycle pulse when the encoder finishes a block.
- `busy`, output, 1: high whenever the state is not `IDLE`.

## Operation

- **FSM states:** `IDLE`, `START`, `BUSY`.
- **`IDLE`:**
  - `in_ready` = 1.
  - A word is accepted on an edge where `in_valid && in_ready`. It is written to bits `[cnt*WORD_W +: WORD_W]`, then `cnt` increments. First word lands in the LSBs.
  - When the accepted word has `cnt == WORDS-1`: `cnt` returns to 0 and the next state is `START`.
- **`START`:**
  - `enc_start` = 1 for exactly one cycle; `in_ready` = 0.
  - Next state is `BUSY` unconditionally.
  - The `armed` flag is cleared.
- **`BUSY`:**
  - `in_ready` = 0.
  - `armed` sets on any cycle where `enc_done` = 0.
  - On an edge where `armed && enc_done`: next state is `IDLE` and `blk_done` = 1 for the following cycle.
  - Consequence: a stale done left high from the previous block never ends the current block. Completion requires a fresh 0→1 transition of `enc_done`.
- **`enc_data_in`:** always equals the assembly register. It is unchanged from entry into `START` until the next word is accepted in `IDLE`.
- **Ignored inputs:**
  - `enc_done` in `IDLE` or `START`.
  - `in_valid` outside `IDLE`; no word is consumed.
- **Reset (asserted at any time, including mid-block or mid-`BUSY`):**
  - state = `IDLE`, `cnt` = 0, `armed` = 0.
  - Assembly register cleared to 0.
  - All outputs return to their reset values.
  - The in-flight block is discarded; no `blk_done` is generated.

## Timing

- **Reset values:** `in_ready` = 1, `enc_start` = 0, `blk_done` = 0, `busy` = 0, `enc_data_in` = 0.
- **Output derivation:** all outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- **Throughput:** one word per cycle while in `IDLE`.
- **Start latency:** `enc_start` is high in the cycle immediately after the edge that accepts the final word.
- **Completion latency:** `blk_done` is high in the cycle immediately after the edge that sees `armed && enc_done`. `in_ready` rises in that same cycle.
- **Minimum block period:** `WORDS` + 2 + encoder latency cycles.

## Configuration

- **Macro:** `LOADER_PAD_EN`.
- **Defined:** `in_last` is honoured.
  - If `in_last` is high on an accepted word at index k < `WORDS-1`, the words k+1 … `WORDS-1` are written to zero in that same edge.
  - Then bit (k+1)·`WORD_W` and bit `N_CELLS-1` are set (pad10*1).
  - The next state is `START`.
  - `in_last` on index `WORDS-1` behaves as a normal full block, with no padding.
- **Undefined:** `in_last` is ignored and has no logic behind it. Every block requires exactly `WORDS` accepted words.

## Structure

- **Shared constants package / ISA include:**
  - FSM state encoding (`LD_IDLE`, `LD_START`, `LD_BUSY`).
  - `WORD_W` default.
  - Reuse of the existing `NUM_CELLS` define.
- **Sub-module:** `loader_fsm`, holding the state register, `armed`, and the `start`/`blk_done` decode. It drives the assembly datapath's write-enable and clear.
- **Datapath:** the counter and assembly register stay in the top level.

## Test plan

Bench uses `WORD_W` = 64 and `N_CELLS` = 1600, so `WORDS` = 25.

- **Full block:** push words 0..24 with value = index, `in_valid` held high.
  - `enc_start` pulses on cycle 26; `enc_data_in[64*i +: 64]` == i.
  - `in_ready` = 0 until `blk_done`.
- **Stale done:** hold `enc_done` = 1 from before `start`, drop it for 1 cycle at `BUSY`+3, raise it again.
  - `blk_done` pulses exactly once, the cycle after the rise; no early exit.
- **Backpressure:** pulse `in_valid` during `BUSY`.
  - No word is consumed.
  - The next block's first word lands at index 0.
- **Reset mid-block:** 10 words accepted, then `rst` for 1 cycle.
  - All outputs return to reset values.
  - The next 25 words form a clean block with no `enc_start` before word 25.
- **`LOADER_PAD_EN`:** 3 words with `in_last` on the third.
  - `enc_start` follows the next cycle.
  - Bit 192 = 1, bit 1599 = 1, all other bits above 191 = 0.
- **Back-to-back:** two blocks with the encoder returning done 5 cycles after each start.
  - Two `blk_done` pulses; the second block's data is intact.

Source files
------------

// File: rtl/encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// encoder_loader_pkg
// Shared constants for the encoder loader slice: FSM state encoding, the
// default input word width and the block width taken from the existing
// NUM_CELLS define (falls back to 1600 cells when nobody has set it).
// Optional feature macro used by this slice: LOADER_PAD_EN.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef NUM_CELLS
`define NUM_CELLS 1600
`endif

package encoder_loader_pkg;

  localparam int LD_WORD_W  = 64;
  localparam int LD_N_CELLS = `NUM_CELLS;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_START = 2'd1,
    LD_BUSY  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/encoder_loader_if.sv
// -----------------------------------------------------------------------------
// encoder_loader_if
// Word stream handshake feeding the loader.
//   in_data  : WORD_W-bit input word
//   in_valid : in_data is valid this cycle
//   in_last  : final word of a short block (only honoured with LOADER_PAD_EN)
//   in_ready : loader accepts a word this cycle
// master = word source, slave = loader.
// -----------------------------------------------------------------------------
interface encoder_loader_if
  import encoder_loader_pkg::*;
#(
  parameter int WORD_W = LD_WORD_W
);

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/encoder_loader_fsm.sv
// -----------------------------------------------------------------------------
// loader_fsm
// Control half of the encoder loader: state register, the armed flag that
// guards against a stale encoder done, and the registered start / block-done
// pulses. Also tells the datapath when to write a word and when to wrap the
// word counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_valid      : input word valid
//   i_final      : the word presented now closes the block
//   i_encDone    : encoder done
//   o_wrEn       : write the presented word into the assembly register
//   o_cntClr     : wrap the word counter back to zero
//   o_ready      : registered in_ready (high only in IDLE)
//   o_start      : one-cycle encoder start pulse
//   o_blkDone    : one-cycle block complete pulse
//   o_busy       : state is not IDLE
// -----------------------------------------------------------------------------
module loader_fsm
  import encoder_loader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_final,
  input  logic i_encDone,
  output logic o_wrEn,
  output logic o_cntClr,
  output logic o_ready,
  output logic o_start,
  output logic o_blkDone,
  output logic o_busy
);

  ld_state_e r_state;
  logic      r_armed;
  logic      r_ready;
  logic      r_start;
  logic      r_blkDone;
  logic      r_busy;
  logic      w_accept;

  // A word is taken whenever the source is valid while we are open; r_ready is
  // a register, so this never forms a path from an input to a top-level output.
  assign w_accept = i_valid && r_ready;
  assign o_wrEn   = w_accept;
  assign o_cntClr = w_accept && i_final;

  assign o_ready   = r_ready;
  assign o_start   = r_start;
  assign o_blkDone = r_blkDone;
  assign o_busy    = r_busy;

  // Single state machine with all visible outputs registered alongside the
  // state. The armed flag is cleared on the START cycle and only sets once the
  // encoder has been seen low in BUSY, so a done left high from the previous
  // block cannot finish this one; a fresh rising done is required.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LD_IDLE;
      r_armed   <= 1'b0;
      r_ready   <= 1'b1;
      r_start   <= 1'b0;
      r_blkDone <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_blkDone <= 1'b0;
      case (r_state)
        LD_IDLE: begin
          if (w_accept && i_final) begin
            r_state <= LD_START;
            r_start <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        LD_START: begin
          r_state <= LD_BUSY;
          r_armed <= 1'b0;
        end
        LD_BUSY: begin
          if (!i_encDone) begin
            r_armed <= 1'b1;
          end
          if (r_armed && i_encDone) begin
            r_state   <= LD_IDLE;
            r_blkDone <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= LD_IDLE;
          r_armed <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/encoder_loader.sv
// -----------------------------------------------------------------------------
// encoder_loader
// Upstream feeder for the encoder core. Collects WORD_W-bit words into an
// N_CELLS-bit block (first word in the LSBs), pulses enc_start when the block
// is complete, holds the block on enc_data_in until the encoder reports a
// fresh done, then reopens for the next block.
// Optional feature: define LOADER_PAD_EN to honour in_last, which closes a
// short block early and applies pad10*1 to the unused upper words.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   s_in         : word stream (encoder_loader_if slave: in_data, in_valid,
//                  in_last, in_ready)
//   enc_start    : one-cycle start pulse to the encoder
//   enc_done     : encoder done
//   enc_data_in  : assembled block driving the encoder data input
//   blk_done     : one-cycle pulse when the encoder finishes a block
//   busy         : high whenever the loader is not IDLE
// -----------------------------------------------------------------------------
module encoder_loader
  import encoder_loader_pkg::*;
#(
  parameter int N_CELLS = `NUM_CELLS,
  parameter int WORD_W  = LD_WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  encoder_loader_if.slave    s_in,
  output logic               enc_start,
  input  logic               enc_done,
  output logic [N_CELLS-1:0] enc_data_in,
  output logic               blk_done,
  output logic               busy
);

  localparam int WORDS = N_CELLS / WORD_W;
  localparam int CNT_W = $clog2(WORDS);

  logic [CNT_W-1:0]   r_cnt;
  logic [N_CELLS-1:0] r_block;
  logic               w_wrEn;
  logic               w_cntClr;
  logic               w_ready;
  logic               w_lastIdx;
  logic               w_final;

  assign w_lastIdx = (r_cnt == CNT_W'(WORDS - 1));

`ifdef LOADER_PAD_EN
  logic w_padHere;
  assign w_final   = w_lastIdx || s_in.in_last;
  assign w_padHere = s_in.in_last && !w_lastIdx;
`else
  assign w_final   = w_lastIdx;
`endif

  loader_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (s_in.in_valid),
    .i_final   (w_final),
    .i_encDone (enc_done),
    .o_wrEn    (w_wrEn),
    .o_cntClr  (w_cntClr),
    .o_ready   (w_ready),
    .o_start   (enc_start),
    .o_blkDone (blk_done),
    .o_busy    (busy)
  );

  assign s_in.in_ready = w_ready;
  assign enc_data_in   = r_block;

  // Word counter and assembly register. Words land at slot r_cnt; the counter
  // wraps when the FSM says the block closed. The block only changes on an
  // accepted word, so it stays put from START until the next block begins.
  // With padding enabled, a short block zeroes every slot above the last word
  // and then sets the first pad bit and the top bit; those later assignments
  // deliberately override the zeroing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_block <= '0;
    end else if (w_wrEn) begin
      r_block[int'(r_cnt)*WORD_W +: WORD_W] <= s_in.in_data;
      if (w_cntClr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
`ifdef LOADER_PAD_EN
      if (w_padHere) begin
        for (int j = 0; j < WORDS; j++) begin
          if (j > int'(r_cnt)) begin
            r_block[j*WORD_W +: WORD_W] <= '0;
          end
        end
        r_block[(int'(r_cnt) + 1)*WORD_W] <= 1'b1;
        r_block[N_CELLS-1]                <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_encoder_loader
// Randomised scoreboard bench for encoder_loader (N_CELLS=1600, WORD_W=64).
// Stimulus feeds words and plays the encoder; a reference model assembles the
// expected blocks from the accepted words and queues them with the cycle the
// start pulse must appear in. A separate monitor pops and compares whenever
// the DUT pulses enc_start or blk_done. Build with LOADER_PAD_EN to exercise
// short-block padding.
// -----------------------------------------------------------------------------
module tb_encoder_loader;

  localparam int N     = 1600;
  localparam int W     = 64;
  localparam int WORDS = N / W;

`ifdef LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enc_done = 1'b0;
  logic         enc_start;
  logic         blk_done;
  logic         busy;
  logic [N-1:0] enc_data_in;

  encoder_loader_if #(.WORD_W(W)) u_if ();

  encoder_loader #(.N_CELLS(N), .WORD_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (u_if),
    .enc_start   (enc_start),
    .enc_done    (enc_done),
    .enc_data_in (enc_data_in),
    .blk_done    (blk_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] blk;
  } expBlk_t;

  expBlk_t      expQ[$];
  int           doneQ[$];
  logic [W-1:0] modelWords[$];
  int           nCompared = 0;
  int           nMismatched = 0;
  int           expDoneTotal = 0;
  int           seenDone = 0;

  expBlk_t      monE;
  logic [N-1:0] held;
  bit           tracking = 0;
  bit           stableErr = 0;
  bit           readyErr = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic checkBlock(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    int bad;
    bad = -1;
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      for (int i = WORDS - 1; i >= 0; i--) begin
        if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
      end
      $display("[TB] FAIL %s: word %0d got %h required %h (cycle %0d)",
               name, bad, act[bad*W +: W], exp[bad*W +: W], cycleCnt);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"},  u_if.in_ready, 1);
    checkOutput({tag, "_enc_start"}, enc_start, 0);
    checkOutput({tag, "_blk_done"},  blk_done, 0);
    checkOutput({tag, "_busy"},      busy, 0);
    checkOutput({tag, "_data_zero"}, |enc_data_in, 0);
  endtask

  // Reference model: collect accepted words; a block closes after WORDS words,
  // or early on in_last when padding is built in.
  task automatic modelAccept(input logic [W-1:0] w, input logic last, input int acc);
    expBlk_t e;
    modelWords.push_back(w);
    if (modelWords.size() == WORDS || (PAD_EN && last)) begin
      e.blk = '0;
      foreach (modelWords[i]) e.blk[i*W +: W] = modelWords[i];
      if (modelWords.size() < WORDS) begin
        e.blk[modelWords.size()*W] = 1'b1;
        e.blk[N-1] = 1'b1;
      end
      e.cyc = acc;
      expQ.push_back(e);
      modelWords.delete();
    end
  endtask

  task automatic sendWord(input logic [W-1:0] w, input logic last, output int acc, output bit ok);
    int n;
    n  = 0;
    ok = 1;
    @(negedge clk);
    u_if.in_data  = w;
    u_if.in_valid = 1'b1;
    u_if.in_last  = last;
    while (!u_if.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!u_if.in_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL ready_timeout: got in_ready=0 for %0d cycles required 1", n);
      u_if.in_valid = 1'b0;
      ok = 0;
      acc = cycleCnt;
    end else begin
      @(posedge clk);
      #1;
      acc = cycleCnt;
    end
  endtask

  task automatic applyStimulus(input int nWords, input bit indexMode, input bit gaps, input int lastAt);
    logic [W-1:0] w;
    int acc, firstAcc;
    bit ok;
    firstAcc = 0;
    acc = 0;
    ok = 1;
    for (int i = 0; i < nWords; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        u_if.in_valid = 1'b0;
      end
      w = indexMode ? W'(i) : {$urandom, $urandom};
      sendWord(w, (i == lastAt), acc, ok);
      if (!ok) break;
      if (i == 0) firstAcc = acc;
      modelAccept(w, (i == lastAt), acc);
    end
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    if (ok && !gaps) checkOutput("throughput", acc - firstAcc, nWords - 1);
  endtask

  task automatic waitStart(output int s);
    int n;
    n = 0;
    @(negedge clk);
    while (!enc_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!enc_start) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL start_timeout: got no enc_start in %0d cycles required a pulse", n);
    end
    s = cycleCnt;
  endtask

  // Encoder plays done low through BUSY, then rises at start+lat for a cycle.
  task automatic finishEncoder(input int s, input int lat);
    while (cycleCnt < s + lat) @(negedge clk);
    enc_done = 1'b1;
    doneQ.push_back(cycleCnt + 1);
    expDoneTotal++;
    @(negedge clk);
    enc_done = 1'b0;
  endtask

  // Monitor: compares the DUT against the queued expectations.
  always @(negedge clk) begin
    if (enc_start) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_start: got enc_start=1 at cycle %0d required 0", cycleCnt);
      end else begin
        monE = expQ.pop_front();
        checkOutput("start_cycle", cycleCnt, monE.cyc);
        checkBlock("block_data", enc_data_in, monE.blk);
      end
      checkOutput("ready_low_at_start", u_if.in_ready, 0);
      held      = enc_data_in;
      tracking  = 1;
      stableErr = 0;
      readyErr  = 0;
    end else if (tracking && busy) begin
      if (enc_data_in !== held) stableErr = 1;
      if (u_if.in_ready !== 1'b0) readyErr = 1;
    end
    if (blk_done) begin
      seenDone++;
      if (doneQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_blk_done: got blk_done=1 at cycle %0d required 0", cycleCnt);
      end else begin
        checkOutput("done_cycle", cycleCnt, doneQ.pop_front());
      end
      checkOutput("ready_at_done", u_if.in_ready, 1);
      if (tracking) begin
        checkOutput("data_held", stableErr, 0);
        checkOutput("ready_held_low", readyErr, 0);
      end
      tracking = 0;
    end else if (!busy && !enc_start) begin
      tracking = 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by cycle %0d required completion", cycleCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, lastAt, nWords;
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
    u_if.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkReset("reset");

    // Full block, value = index, valid held high.
    applyStimulus(WORDS, 1, 0, -1);
    waitStart(s);
    finishEncoder(s, 5);

    // Stale done: high before start, low for one cycle at BUSY+3, then high.
    enc_done = 1'b1;
    applyStimulus(WORDS, 0, 0, -1);
    waitStart(s);
    while (cycleCnt < s + 4) @(negedge clk);
    enc_done = 1'b0;
    @(negedge clk);
    enc_done = 1'b1;
    doneQ.push_back(cycleCnt + 1);
    expDoneTotal++;
    repeat (3) @(negedge clk);
    enc_done = 1'b0;

    // Backpressure: valid pulsed during BUSY must not be consumed.
    applyStimulus(WORDS, 0, 1, -1);
    waitStart(s);
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (3) @(negedge clk);
    u_if.in_valid = 1'b0;
    finishEncoder(s, 6);
    applyStimulus(WORDS, 0, 0, -1);
    waitStart(s);
    finishEncoder(s, 3);

    // Reset mid-block after 10 words.
    applyStimulus(10, 0, 0, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelWords.delete();
    checkReset("midblock");
    applyStimulus(WORDS, 0, 0, -1);
    waitStart(s);
    finishEncoder(s, 4);

    // Reset while BUSY: block discarded, no blk_done.
    applyStimulus(WORDS, 0, 1, -1);
    waitStart(s);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("midbusy");

`ifdef LOADER_PAD_EN
    // Short block: 3 words, in_last on the third.
    applyStimulus(3, 0, 0, 2);
    waitStart(s);
    checkOutput("pad_bit192", enc_data_in[192], 1);
    checkOutput("pad_bit1599", enc_data_in[1599], 1);
    checkOutput("pad_zero_mid", |enc_data_in[1598:193], 0);
    finishEncoder(s, 4);
`endif

    // Back-to-back blocks, done 5 cycles after each start.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(WORDS, 0, 0, -1);
      waitStart(s);
      finishEncoder(s, 5);
    end

    // Random blocks with gaps, random in_last and random encoder latency.
    for (int k = 0; k < 4; k++) begin
      lastAt = $urandom_range(0, WORDS - 1);
`ifdef LOADER_PAD_EN
      nWords = lastAt + 1;
`else
      nWords = WORDS;
`endif
      applyStimulus(nWords, 0, 1, lastAt);
      waitStart(s);
      finishEncoder(s, $urandom_range(2, 8));
    end

    repeat (10) @(negedge clk);
    checkOutput("exp_queue_empty", expQ.size(), 0);
    checkOutput("done_queue_empty", doneQ.size(), 0);
    checkOutput("done_count", seenDone, expDoneTotal);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
